// File: rtl/lcd_pkg.sv
// Shared LCD bus definitions used by both the read and write controllers.
package lcd_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned CONT_W   = 5;
    localparam int unsigned TRIES_W  = 8;

    // Bit of the status byte that reports the controller busy flag.
    localparam int unsigned BUSY_BIT = 7;

    // LCD_RW levels: high reads from the panel, low hands the bus to the writer.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_EN_HIGH = 2'd2,
        ST_HOLD    = 2'd3
    } lcd_state_t;

    // A busy-flag poll always addresses the instruction/status register.
    function automatic logic sel_rs(input logic poll, input logic rs);
        return poll ? 1'b0 : rs;
    endfunction

endpackage

// File: rtl/lcd_reader.sv
// LCD read controller: single register reads and busy-flag polling with timeout.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_Divide = 16,
    parameter int unsigned POLL_LIMIT = 255
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iStart,
    input  logic              iRS,
    input  logic              iPoll,
    input  logic [DATA_W-1:0] LCD_DATA_IN,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDone,
    output logic              oTimeout,
    output logic              LCD_EN,
    output logic              LCD_RW,
    output logic              LCD_RS
);

    localparam logic [CONT_W-1:0]  CONT_LAST  = CONT_W'(CLK_Divide - 1);
    localparam logic [TRIES_W-1:0] TRIES_LAST = TRIES_W'(POLL_LIMIT - 1);

    lcd_state_t         state;
    logic [CONT_W-1:0]  cont;
    logic [TRIES_W-1:0] tries;
    logic               start_q;
    logic               start_armed;
    logic               poll_q;
    logic               start_rise_c;

    // A low level must be seen after reset before any edge counts, so iStart
    // held high across reset release cannot look like a fresh request.
    assign start_rise_c = start_armed & ~start_q & iStart;

    // Read sequencer: address setup, enable strobe, hold, optional re-poll.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state       <= ST_IDLE;
            cont        <= '0;
            tries       <= '0;
            start_q     <= 1'b0;
            start_armed <= 1'b0;
            poll_q      <= 1'b0;
            oDATA       <= '0;
            oDone       <= 1'b0;
            oTimeout    <= 1'b0;
            LCD_EN      <= 1'b0;
            LCD_RW      <= RW_WRITE;
            LCD_RS      <= 1'b0;
        end else begin
            start_q <= iStart;
            if (!iStart) begin
                start_armed <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    LCD_EN <= 1'b0;
                    LCD_RW <= RW_WRITE;
                    if (start_rise_c) begin
                        poll_q   <= iPoll;
                        LCD_RS   <= sel_rs(iPoll, iRS);
                        oDone    <= 1'b0;
                        oTimeout <= 1'b0;
                        tries    <= '0;
                        LCD_RW   <= RW_READ;
                        state    <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    LCD_EN <= 1'b1;
                    cont   <= '0;
                    state  <= ST_EN_HIGH;
                end

                ST_EN_HIGH: begin
                    cont <= cont + CONT_W'(1);
                    if (cont == CONT_LAST) begin
                        oDATA  <= LCD_DATA_IN;
                        LCD_EN <= 1'b0;
                        state  <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (!poll_q || !oDATA[BUSY_BIT]) begin
                        LCD_RW <= RW_WRITE;
                        oDone  <= 1'b1;
                        state  <= ST_IDLE;
                    end else if (tries == TRIES_LAST) begin
                        LCD_RW   <= RW_WRITE;
                        oDone    <= 1'b1;
                        oTimeout <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        tries <= tries + TRIES_W'(1);
                        state <= ST_SETUP;
                    end
                end

                default: begin
                    LCD_EN <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_reader.sv
// Randomized self-checking bench for lcd_reader (CLK_Divide=4, POLL_LIMIT=3).
module tb_lcd_reader;

    localparam int DIV   = 4;
    localparam int LIMIT = 3;

    logic       iCLK;
    logic       iRST_N;
    logic       iStart;
    logic       iRS;
    logic       iPoll;
    logic [7:0] LCD_DATA_IN;
    logic [7:0] oDATA;
    logic       oDone;
    logic       oTimeout;
    logic       LCD_EN;
    logic       LCD_RW;
    logic       LCD_RS;

    int checks = 0;
    int errors = 0;

    // Bytes the panel returns on successive strobes of one transaction.
    logic [7:0] data_seq [0:7];

    lcd_reader #(.CLK_Divide(DIV), .POLL_LIMIT(LIMIT)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart), .iRS(iRS), .iPoll(iPoll),
        .LCD_DATA_IN(LCD_DATA_IN), .oDATA(oDATA), .oDone(oDone), .oTimeout(oTimeout),
        .LCD_EN(LCD_EN), .LCD_RW(LCD_RW), .LCD_RS(LCD_RS)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: read strobes until the byte is not busy (or not polling), capped at LIMIT.
    function automatic void model(input bit poll, output int n, output bit to, output logic [7:0] d);
        n  = 0;
        to = 1'b0;
        d  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            d = data_seq[i];
            n = i + 1;
            if (!poll || !d[7]) break;
            if (n == LIMIT) begin
                to = 1'b1;
                break;
            end
        end
    endfunction

    // One transaction from a negedge: pulse (or hold) iStart, drive panel data, check all outputs.
    task automatic run_txn(input bit poll, input bit rs, input bit extra_start, input bit hold_start);
        int         exp_n;
        bit         exp_to;
        logic [7:0] exp_d;
        logic       exp_rs;
        int         cyc = 0;
        int         pulses = 0;
        int         falls = 0;
        int         en_cyc = 0;
        int         rs_bad = 0;
        int         rw_bad = 0;
        int         late = 0;
        logic       en_prev = 1'b0;

        model(poll, exp_n, exp_to, exp_d);
        exp_rs      = poll ? 1'b0 : rs;
        iPoll       = poll;
        iRS         = rs;
        LCD_DATA_IN = data_seq[0];
        iStart      = 1'b1;
        @(negedge iCLK);
        if (!hold_start) iStart = 1'b0;
        iRS   = 1'($urandom);
        iPoll = 1'($urandom);
        while (cyc < 200) begin
            @(negedge iCLK);
            cyc++;
            if (LCD_EN && !en_prev) pulses++;
            if (!LCD_EN && en_prev) falls++;
            if (LCD_EN) en_cyc++;
            en_prev     = LCD_EN;
            LCD_DATA_IN = data_seq[falls < 7 ? falls : 7];
            if (LCD_EN && LCD_RS !== exp_rs) rs_bad++;
            if (!oDone && LCD_RW !== 1'b1) rw_bad++;
            if (extra_start && !hold_start && cyc == 3) iStart = 1'b1;
            if (extra_start && !hold_start && cyc == 4) iStart = 1'b0;
            if (oDone) break;
        end
        check_eq("latency", 32'(cyc), 32'(exp_n * (DIV + 2)));
        check_eq("en_pulses", 32'(pulses), 32'(exp_n));
        check_eq("en_cycles", 32'(en_cyc), 32'(exp_n * DIV));
        check_eq("data", 32'(oDATA), 32'(exp_d));
        check_eq("timeout", 32'(oTimeout), 32'(exp_to));
        check_eq("rs_stable", 32'(rs_bad), 32'd0);
        check_eq("rw_read", 32'(rw_bad), 32'd0);
        check_eq("rw_after", 32'(LCD_RW), 32'd0);
        if (hold_start) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge iCLK);
                if (LCD_EN || !oDone) late++;
            end
            check_eq("level_hold", 32'(late), 32'd0);
            iStart = 1'b0;
        end
        @(negedge iCLK);
    endtask

    // Mid-strobe reset must clear outputs at once; iStart held across release starts nothing.
    task automatic reset_mid_strobe();
        int wait_cyc = 0;
        int stray = 0;
        data_seq[0] = 8'h3C;
        iPoll  = 1'b0;
        iRS    = 1'b1;
        iStart = 1'b1;
        while (!LCD_EN && wait_cyc < 20) begin
            @(negedge iCLK);
            wait_cyc++;
        end
        check_eq("rst_saw_en", 32'(LCD_EN), 32'd1);
        #2;
        iRST_N = 1'b0;
        #1;
        check_eq("rst_en", 32'(LCD_EN), 32'd0);
        check_eq("rst_rw", 32'(LCD_RW), 32'd0);
        check_eq("rst_done", 32'(oDone), 32'd0);
        check_eq("rst_data", 32'(oDATA), 32'd0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge iCLK);
            if (LCD_EN || LCD_RW || oDone) stray++;
        end
        check_eq("rst_no_resume", 32'(stray), 32'd0);
        iStart = 1'b0;
        @(negedge iCLK);
        @(negedge iCLK);
    endtask

    initial begin
        int nbusy;
        bit poll;
        iRST_N      = 1'b0;
        iStart      = 1'b0;
        iRS         = 1'b0;
        iPoll       = 1'b0;
        LCD_DATA_IN = 8'h00;
        for (int i = 0; i < 8; i++) data_seq[i] = 8'h00;
        #1;
        check_eq("reset_en", 32'(LCD_EN), 32'd0);
        check_eq("reset_rw", 32'(LCD_RW), 32'd0);
        check_eq("reset_rs", 32'(LCD_RS), 32'd0);
        check_eq("reset_done", 32'(oDone), 32'd0);
        check_eq("reset_to", 32'(oTimeout), 32'd0);
        check_eq("reset_data", 32'(oDATA), 32'd0);
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);

        data_seq[0] = 8'h5A;
        run_txn(1'b0, 1'b1, 1'b0, 1'b0);

        data_seq[0] = 8'h80; data_seq[1] = 8'h80;
        for (int i = 2; i < 8; i++) data_seq[i] = 8'h05;
        run_txn(1'b1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) data_seq[i] = 8'hFF;
        run_txn(1'b1, 1'b0, 1'b0, 1'b0);

        data_seq[0] = 8'hC3;
        run_txn(1'b0, 1'b0, 1'b1, 1'b0);

        data_seq[0] = 8'h81; data_seq[1] = 8'h22;
        run_txn(1'b1, 1'b1, 1'b0, 1'b1);

        reset_mid_strobe();

        for (int t = 0; t < 30; t++) begin
            poll  = 1'($urandom);
            nbusy = int'($urandom_range(0, 4));
            for (int i = 0; i < 8; i++) begin
                data_seq[i] = 8'($urandom);
                if (poll) data_seq[i][7] = (i < nbusy);
            end
            run_txn(poll, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
            repeat (int'($urandom_range(0, 3))) @(negedge iCLK);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_reader.md
LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 Parameter CLK_Divide, default 16, number of iCLK cycles LCD_EN is held high per read strobe (legal 2..31).
REQ-002 Parameter POLL_LIMIT, default 255, maximum busy-flag reads per poll command before timeout (legal 1..255).
REQ-003 iCLK  in  1  system clock; all state changes on rising edge.
REQ-004 iRST_N  in  1  asynchronous active-low reset.
REQ-005 iStart  in  1  command request; rising edge (registered 0 then sampled 1) starts a transaction.
REQ-006 iRS  in  1  register select for single read (0 = instruction/status, 1 = data RAM).
REQ-007 iPoll  in  1  1 = busy-flag poll command; forces RS=0 and ignores iRS.
REQ-008 LCD_DATA_IN  in  8  data bus driven by the LCD during read.
REQ-009 oDATA  out  8  last byte sampled from LCD_DATA_IN.
REQ-010 oDone  out  1  transaction complete; held high until the next accepted start.
REQ-011 oTimeout  out  1  poll command ended with the busy flag still set.
REQ-012 LCD_EN  out  1  LCD enable strobe.
REQ-013 LCD_RW  out  1  1 = read cycle; 0 otherwise, releasing the bus to the writer.
REQ-014 LCD_RS  out  1  register select to the LCD.

Function
REQ-015 The block SHALL have states IDLE, SETUP, EN_HIGH, HOLD, plus a 5-bit strobe counter Cont and an 8-bit poll counter Tries.
REQ-016 IDLE: on a detected iStart rising edge the block SHALL latch rs = iPoll ? 0 : iRS, latch iPoll, clear oDone, oTimeout and Tries, set LCD_RW=1, drive LCD_RS=rs, and go to SETUP.
REQ-017 SETUP: one cycle of address setup with LCD_EN=0; it then SHALL set LCD_EN=1 and Cont=0 and go to EN_HIGH.
REQ-018 EN_HIGH: Cont SHALL increment each cycle; on the cycle with Cont==CLK_Divide-1 it SHALL capture LCD_DATA_IN into oDATA, set LCD_EN=0, and go to HOLD; LCD_EN is therefore high for exactly CLK_Divide cycles.
REQ-019 HOLD (LCD_RW still 1, one cycle): if not polling, or oDATA[7]==0, the block SHALL set LCD_RW=0 and oDone=1 and go to IDLE.
REQ-020 HOLD, polling with oDATA[7]==1: if Tries==POLL_LIMIT-1 it SHALL set LCD_RW=0, oDone=1 and oTimeout=1 and go to IDLE; otherwise it SHALL increment Tries and go to SETUP with LCD_RW held at 1.
REQ-021 Latency: oDone SHALL rise CLK_Divide+2 cycles after the detecting edge for a single read; each poll iteration SHALL take CLK_Divide+2 cycles.
REQ-022 iStart edges outside IDLE SHALL be ignored and SHALL NOT be queued; the edge detector keeps tracking iStart in every state.
REQ-023 iRS and iPoll changes after the start is accepted SHALL NOT affect the transaction in progress.
REQ-024 LCD_RS and LCD_RW SHALL be stable for the whole period LCD_EN is high.
REQ-025 LCD_RW SHALL be 0 in IDLE.

Reset
REQ-026 iRST_N low SHALL asynchronously force IDLE, with LCD_EN=0, LCD_RW=0, LCD_RS=0, oDone=0, oTimeout=0, oDATA=8'h00, Cont=0, Tries=0 and the edge-detect register=0.
REQ-027 Reset asserted mid-transaction SHALL drop LCD_EN immediately; after release, no transaction resumes until a new iStart rising edge.

Structure
REQ-028 State encoding, the busy-flag bit index (7) and the LCD_RW read/write constants SHALL live in the shared package lcd_pkg, which the write controller also uses.
REQ-029 Implementation SHALL be a single module with no sub-modules; the start edge detector is inline.

Verification (CLK_Divide=4, POLL_LIMIT=3)
REQ-030 Single read: iRS=1, iPoll=0, LCD_DATA_IN=8'h5A, pulse iStart -> LCD_RW=1 and LCD_RS=1; LCD_EN high 4 cycles; oDATA=8'h5A; oDone rises 6 cycles after detection; then LCD_RW=0.
REQ-031 Poll clears: iPoll=1, LCD_DATA_IN=8'h80 for the first 2 strobes then 8'h05 -> 3 EN pulses, LCD_RS=0, oDATA=8'h05, oDone=1, oTimeout=0 at 18 cycles.
REQ-032 Poll timeout: LCD_DATA_IN held at 8'hFF -> exactly 3 EN pulses, then oDone=1, oTimeout=1, oDATA=8'hFF.
REQ-033 Start while busy: second iStart edge during EN_HIGH -> ignored; exactly one oDone rise; no extra EN pulse.
REQ-034 Reset mid-strobe: assert iRST_N=0 while LCD_EN=1 -> LCD_EN, LCD_RW, oDone and oDATA go to 0 without waiting for a clock; iStart held high through release starts nothing.
REQ-035 Level hold: iStart held high for 20 cycles after completion -> no second transaction; oDone stays 1.
